multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control unit for the RISC-V core. It replaces the purely combinational opcode decoder with a registered Moore state machine that sequences fetch, decode, execute, memory and write-back over several clock cycles. It waits on a memory-ready handshake, counts retired instructions, and traps unsupported opcodes. It sits between the instruction register's opcode field and the multi-cycle datapath: PC, IR, shared memory port, register file and ALU muxes.

## Interface
- ALU_OP_WIDTH, 3: width of alu_op_o; the datapath ALU control decodes it together with funct3/funct7.
- CNT_WIDTH, 32: width of the retired-instruction counter.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- op_i  input  7  opcode from the instruction register, sampled only in DECODE
- mem_ready_i  input  1  memory has completed the current access this cycle
- pc_write_o  output  1  unconditional PC update
- pc_write_cond_o  output  1  PC update qualified by the datapath branch comparison
- ir_write_o  output  1  load the instruction register
- i_or_d_o  output  1  memory address source: 0 = PC, 1 = ALU result register
- mem_read_o, mem_write_o  output  1 each  memory strobes, held until mem_ready_i
- mem_to_reg_o  output  2  write-back source: 0 = ALU result, 1 = memory data, 2 = PC+4
- reg_write_o  output  1  register-file write enable
- alu_src_a_o  output  2  ALU A operand: 0 = PC, 1 = rs1, 2 = zero
- alu_src_b_o  output  2  ALU B operand: 0 = rs2, 1 = constant 4, 2 = immediate
- alu_op_o  output  ALU_OP_WIDTH  0 = add, 1 = I-type logic, 2 = R-type, 3 = branch compare
- pc_src_o  output  2  PC source: 0 = ALU output, 1 = ALU result register, 2 = ALU output with bit 0 cleared
- illegal_op_o  output  1  sticky flag for an unsupported opcode
- state_o  output  4  current state encoding, for debug
- instr_count_o  output  CNT_WIDTH  retired-instruction count

## Operation
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_READ = 4, LOAD_WB = 5, MEM_WRITE = 6, EXEC_R = 7, EXEC_I = 8, ALU_WB = 9, BRANCH = 10, LUI = 11, JAL = 12, JALR = 13, TRAP = 15.
- Every output not listed for a state is 0.
- IDLE: all outputs 0. Unconditionally goes to FETCH.
- FETCH: i_or_d = 0, mem_read = 1, alu_src_a = 0, alu_src_b = 1, alu_op = 0.
  - ir_write and pc_write are asserted only in the cycle where mem_ready_i = 1; that cycle also moves to DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE: computes the branch target (alu_src_a = 0, alu_src_b = 2, alu_op = 0). Next state by op_i:
  - 0x33 -> EXEC_R; 0x13 -> EXEC_I; 0x03 and 0x23 -> MEM_ADDR; 0x63 -> BRANCH; 0x37 -> LUI.
  - 0x6F -> JAL and 0x67 -> JALR, only when JUMP_EN is defined.
  - Any other value -> TRAP.
- EXEC_R: alu_src_a = 1, alu_src_b = 0, alu_op = 2; next ALU_WB.
- EXEC_I: alu_src_a = 1, alu_src_b = 2, alu_op = 1; next ALU_WB.
- ALU_WB: reg_write = 1, mem_to_reg = 0; retires the instruction; next FETCH.
- LUI: alu_src_a = 2, alu_src_b = 2, alu_op = 0; next ALU_WB.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, alu_op = 0. Next MEM_READ for a load, MEM_WRITE for a store; the opcode is held from DECODE.
- MEM_READ: i_or_d = 1, mem_read = 1; stays until mem_ready_i = 1, then LOAD_WB.
- LOAD_WB: reg_write = 1, mem_to_reg = 1; retires; next FETCH.
- MEM_WRITE: i_or_d = 1, mem_write = 1; stays until mem_ready_i = 1, then retires and goes to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = 3, pc_write_cond = 1, pc_src = 1; retires; next FETCH.
- TRAP: all strobes 0, illegal_op_o = 1. Stays in TRAP until reset.
- Retirement: instr_count_o increments by 1 on each retirement. It wraps modulo 2^CNT_WIDTH with no saturation.

## Timing
- Reset, asynchronous, regardless of current state or an outstanding memory access:
  - state = IDLE
  - every output = 0
  - instr_count_o = 0
  - illegal_op_o = 0
- First FETCH is the cycle after reset deasserts.
- Outputs are combinational from the state register. The only exceptions are the FETCH ir_write/pc_write qualification and the memory exits, which depend on mem_ready_i.
- Cycles per instruction with mem_ready_i tied high:
  - R, I, LUI: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL, JALR: 3
- Each cycle of mem_ready_i = 0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- mem_ready_i is ignored in all other states.
- op_i is ignored outside DECODE.
- instr_count_o updates on the clock edge that leaves the retiring state.

## Configuration
- JUMP_EN, defined: JAL and JALR states exist. Both assert:
  - alu_src_a = 0, alu_src_b = 1, reg_write = 1, mem_to_reg = 2, pc_write = 1
  - JAL: pc_src = 1. JALR: pc_src = 2.
  - Both retire and go to FETCH.
- JUMP_EN, undefined: opcodes 0x6F and 0x67 go to TRAP. State codes 12 and 13 are unreachable.

## Test plan
- Reset with mem_ready_i = 1 -> state_o = 0 and all outputs 0; cycle 1 state_o = 1 with ir_write = 1.
- R-type (op_i = 0x33), zero-wait memory -> states 1, 2, 7, 9, 1; reg_write high only in state 9; instr_count_o = 1 after 4 cycles.
- Load (0x03) with mem_ready_i low for 3 cycles in MEM_READ -> 8 cycles total; mem_read_o and i_or_d_o held high throughout the wait.
- Store (0x23) followed by branch (0x63) -> mem_write pulse in state 6, then pc_write_cond = 1 in state 10; count = 2 after 7 cycles.
- op_i = 0x7F, then op_i = 0x6F without JUMP_EN -> TRAP both times; illegal_op_o stays 1; count frozen until reset.
- Reset asserted mid-MEM_READ, and the counter preloaded to 2^CNT_WIDTH − 1 then retired once -> immediate return to IDLE; counter wraps to 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control-side bundle between multicycle_control and the multi-cycle datapath.
// master = control unit, slave = datapath/memory side.
interface multicycle_control_if #(
   parameter int ALU_OP_WIDTH = 3,
   parameter int CNT_WIDTH    = 32
);
   logic [6:0]              op_i;
   logic                    mem_ready_i;
   logic                    pc_write_o;
   logic                    pc_write_cond_o;
   logic                    ir_write_o;
   logic                    i_or_d_o;
   logic                    mem_read_o;
   logic                    mem_write_o;
   logic [1:0]              mem_to_reg_o;
   logic                    reg_write_o;
   logic [1:0]              alu_src_a_o;
   logic [1:0]              alu_src_b_o;
   logic [ALU_OP_WIDTH-1:0] alu_op_o;
   logic [1:0]              pc_src_o;
   logic                    illegal_op_o;
   logic [3:0]              state_o;
   logic [CNT_WIDTH-1:0]    instr_count_o;

   modport master (
      input  op_i, mem_ready_i,
      output pc_write_o, pc_write_cond_o, ir_write_o, i_or_d_o, mem_read_o,
             mem_write_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
             alu_op_o, pc_src_o, illegal_op_o, state_o, instr_count_o
   );

   modport slave (
      output op_i, mem_ready_i,
      input  pc_write_o, pc_write_cond_o, ir_write_o, i_or_d_o, mem_read_o,
             mem_write_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
             alu_op_o, pc_src_o, illegal_op_o, state_o, instr_count_o
   );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle RISC-V datapath with retired-instruction counter.
// Define JUMP_EN to add the JAL/JALR states; otherwise those opcodes trap.
module multicycle_control #(
   parameter int ALU_OP_WIDTH = 3,
   parameter int CNT_WIDTH    = 32
) (
   input logic                 clk,
   input logic                 reset,
   multicycle_control_if.master ctl
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_LOAD_WB   = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXEC_R    = 4'd7,
      S_EXEC_I    = 4'd8,
      S_ALU_WB    = 4'd9,
      S_BRANCH    = 4'd10,
      S_LUI       = 4'd11,
      S_JAL       = 4'd12,
      S_JALR      = 4'd13,
      S_TRAP      = 4'd15
   } state_t;

   state_t               state_q, state_d;
   logic                 is_store_q, is_store_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 retire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         is_store_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         count_q    <= count_d;
      end
   end

   // The load/store distinction is captured in DECODE because op_i is not trusted afterwards.
   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      retire     = 1'b0;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (ctl.mem_ready_i) state_d = S_DECODE;
         S_DECODE: begin
            is_store_d = (ctl.op_i == 7'h23);
            case (ctl.op_i)
               7'h33:        state_d = S_EXEC_R;
               7'h13:        state_d = S_EXEC_I;
               7'h03, 7'h23: state_d = S_MEM_ADDR;
               7'h63:        state_d = S_BRANCH;
               7'h37:        state_d = S_LUI;
`ifdef JUMP_EN
               7'h6F:        state_d = S_JAL;
               7'h67:        state_d = S_JALR;
`endif
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEM_ADDR: state_d = is_store_q ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ: if (ctl.mem_ready_i) state_d = S_LOAD_WB;
         S_MEM_WRITE: begin
            if (ctl.mem_ready_i) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXEC_R, S_EXEC_I, S_LUI: state_d = S_ALU_WB;
         S_ALU_WB, S_LOAD_WB, S_BRANCH: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
`ifdef JUMP_EN
         S_JAL, S_JALR: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
`endif
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
      count_d = retire ? count_q + CNT_WIDTH'(1) : count_q;
   end

   always_comb begin
      ctl.pc_write_o      = 1'b0;
      ctl.pc_write_cond_o = 1'b0;
      ctl.ir_write_o      = 1'b0;
      ctl.i_or_d_o        = 1'b0;
      ctl.mem_read_o      = 1'b0;
      ctl.mem_write_o     = 1'b0;
      ctl.mem_to_reg_o    = 2'd0;
      ctl.reg_write_o     = 1'b0;
      ctl.alu_src_a_o     = 2'd0;
      ctl.alu_src_b_o     = 2'd0;
      ctl.alu_op_o        = '0;
      ctl.pc_src_o        = 2'd0;
      ctl.illegal_op_o    = 1'b0;
      case (state_q)
         S_FETCH: begin
            ctl.mem_read_o  = 1'b1;
            ctl.alu_src_b_o = 2'd1;
            ctl.ir_write_o  = ctl.mem_ready_i;
            ctl.pc_write_o  = ctl.mem_ready_i;
         end
         S_DECODE:   ctl.alu_src_b_o = 2'd2;
         S_MEM_ADDR: begin
            ctl.alu_src_a_o = 2'd1;
            ctl.alu_src_b_o = 2'd2;
         end
         S_MEM_READ: begin
            ctl.i_or_d_o   = 1'b1;
            ctl.mem_read_o = 1'b1;
         end
         S_LOAD_WB: begin
            ctl.reg_write_o  = 1'b1;
            ctl.mem_to_reg_o = 2'd1;
         end
         S_MEM_WRITE: begin
            ctl.i_or_d_o    = 1'b1;
            ctl.mem_write_o = 1'b1;
         end
         S_EXEC_R: begin
            ctl.alu_src_a_o = 2'd1;
            ctl.alu_op_o    = ALU_OP_WIDTH'(2);
         end
         S_EXEC_I: begin
            ctl.alu_src_a_o = 2'd1;
            ctl.alu_src_b_o = 2'd2;
            ctl.alu_op_o    = ALU_OP_WIDTH'(1);
         end
         S_ALU_WB: ctl.reg_write_o = 1'b1;
         S_BRANCH: begin
            ctl.alu_src_a_o     = 2'd1;
            ctl.alu_op_o        = ALU_OP_WIDTH'(3);
            ctl.pc_write_cond_o = 1'b1;
            ctl.pc_src_o        = 2'd1;
         end
         S_LUI: begin
            ctl.alu_src_a_o = 2'd2;
            ctl.alu_src_b_o = 2'd2;
         end
`ifdef JUMP_EN
         S_JAL, S_JALR: begin
            ctl.alu_src_b_o  = 2'd1;
            ctl.reg_write_o  = 1'b1;
            ctl.mem_to_reg_o = 2'd2;
            ctl.pc_write_o   = 1'b1;
            ctl.pc_src_o     = (state_q == S_JAL) ? 2'd1 : 2'd2;
         end
`endif
         S_TRAP:  ctl.illegal_op_o = 1'b1;
         default: ;
      endcase
   end

   assign ctl.state_o       = state_q;
   assign ctl.instr_count_o = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: a per-instruction cycle model
// pushes expected per-cycle behaviour; a negedge monitor pops and compares.
module tb_multicycle_control;

   localparam int AW = 3;
   localparam int CW = 4;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_src;
      logic       illegal;
   } ctrl_t;

   typedef struct {
      logic [3:0]    state;
      ctrl_t         ctrl;
      logic [CW-1:0] count;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t exp_q[$];
   logic [CW-1:0] model_count;
   int checks = 0;
   int errors = 0;

   multicycle_control_if #(.ALU_OP_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   multicycle_control #(.ALU_OP_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .ctl   (bus)
   );

   always #5 clk = ~clk;

   // Expected control word for each state, written directly from the state table.
   function automatic ctrl_t exp_ctrl(int st, logic rdy);
      ctrl_t c;
      c = '0;
      case (st)
         1: begin c.mem_read = 1; c.src_b = 1; c.ir_write = rdy; c.pc_write = rdy; end
         2: c.src_b = 2;
         3: begin c.src_a = 1; c.src_b = 2; end
         4: begin c.i_or_d = 1; c.mem_read = 1; end
         5: begin c.reg_write = 1; c.mem_to_reg = 1; end
         6: begin c.i_or_d = 1; c.mem_write = 1; end
         7: begin c.src_a = 1; c.alu_op = 2; end
         8: begin c.src_a = 1; c.src_b = 2; c.alu_op = 1; end
         9: c.reg_write = 1;
         10: begin c.src_a = 1; c.alu_op = 3; c.pc_write_cond = 1; c.pc_src = 1; end
         11: begin c.src_a = 2; c.src_b = 2; end
         12, 13: begin
            c.src_b = 1; c.reg_write = 1; c.mem_to_reg = 2; c.pc_write = 1;
            c.pc_src = (st == 12) ? 2'd1 : 2'd2;
         end
         15: c.illegal = 1;
         default: ;
      endcase
      return c;
   endfunction

   // One clock cycle: drive inputs, record what the DUT must show, advance to next edge+1.
   task automatic applyStimulus(int st, logic rdy, logic [6:0] op);
      exp_t e;
      bus.mem_ready_i = rdy;
      bus.op_i        = op;
      e.state = 4'(st);
      e.ctrl  = exp_ctrl(st, rdy);
      e.count = model_count;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic retire_step(int st, logic rdy);
      applyStimulus(st, rdy, 7'($urandom));
      model_count = model_count + CW'(1);
   endtask

   task automatic do_reset();
      exp_t e;
      e.state = 4'd0;
      e.ctrl  = '0;
      e.count = '0;
      reset = 1'b1;
      bus.mem_ready_i = 1'b1;
      bus.op_i = 7'($urandom);
      model_count = '0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Cycle-level walk of one instruction; abort resets the core during a MEM_READ wait.
   task automatic run_instr(logic [6:0] op, int fw, int mw, bit abort);
      repeat (fw) applyStimulus(1, 1'b0, 7'($urandom));
      applyStimulus(1, 1'b1, 7'($urandom));
      applyStimulus(2, 1'($urandom), op);
      case (op)
         7'h33: begin applyStimulus(7, 1'($urandom), 7'($urandom)); retire_step(9, 1'($urandom)); end
         7'h13: begin applyStimulus(8, 1'($urandom), 7'($urandom)); retire_step(9, 1'($urandom)); end
         7'h37: begin applyStimulus(11, 1'($urandom), 7'($urandom)); retire_step(9, 1'($urandom)); end
         7'h63: retire_step(10, 1'($urandom));
         7'h03: begin
            applyStimulus(3, 1'($urandom), 7'($urandom));
            repeat (mw) applyStimulus(4, 1'b0, 7'($urandom));
            if (abort) begin
               do_reset();
            end else begin
               applyStimulus(4, 1'b1, 7'($urandom));
               retire_step(5, 1'($urandom));
            end
         end
         7'h23: begin
            applyStimulus(3, 1'($urandom), 7'($urandom));
            repeat (mw) applyStimulus(6, 1'b0, 7'($urandom));
            retire_step(6, 1'b1);
         end
`ifdef JUMP_EN
         7'h6F: retire_step(12, 1'($urandom));
         7'h67: retire_step(13, 1'($urandom));
`endif
         default: begin
            repeat (1 + $urandom % 3) applyStimulus(15, 1'($urandom), 7'($urandom));
            do_reset();
         end
      endcase
   endtask

   task automatic checkOutput(exp_t e);
      ctrl_t act;
      act = '{bus.pc_write_o, bus.pc_write_cond_o, bus.ir_write_o, bus.i_or_d_o,
              bus.mem_read_o, bus.mem_write_o, bus.mem_to_reg_o, bus.reg_write_o,
              bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o, bus.pc_src_o,
              bus.illegal_op_o};
      checks++;
      if (bus.state_o !== e.state) begin
         errors++;
         $display("[TB] FAIL state at %0t: got %0d expected %0d", $time, bus.state_o, e.state);
      end
      checks++;
      if (act !== e.ctrl) begin
         errors++;
         $display("[TB] FAIL ctrl at %0t (state %0d): got %h expected %h",
                  $time, e.state, act, e.ctrl);
      end
      checks++;
      if (bus.instr_count_o !== e.count) begin
         errors++;
         $display("[TB] FAIL count at %0t: got %0d expected %0d", $time, bus.instr_count_o, e.count);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
   end

   initial begin
      logic [6:0] legal [6];
      logic [6:0] op;
      int r, fw, mw;
      legal = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37};
      reset = 1'b1;
      bus.mem_ready_i = 1'b1;
      bus.op_i = 7'h00;
      model_count = '0;
      @(posedge clk);
      #1;
      do_reset();

      // Directed: enough zero-wait instructions to wrap the 4-bit counter.
      for (int i = 0; i < 18; i++) run_instr(legal[i % 6], 0, 0, 1'b0);
      run_instr(7'h03, 0, 3, 1'b0);
      run_instr(7'h23, 0, 0, 1'b0);
      run_instr(7'h63, 0, 0, 1'b0);
      run_instr(7'h7F, 1, 0, 1'b0);
      run_instr(7'h6F, 0, 0, 1'b0);
      run_instr(7'h67, 0, 0, 1'b0);
      run_instr(7'h33, 0, 0, 1'b0);
      run_instr(7'h03, 0, 2, 1'b1);

      for (int i = 0; i < 250; i++) begin
         r = int'($urandom % 20);
         if (r < 17)       op = legal[r % 6];
         else if (r == 17) op = 7'h6F;
         else if (r == 18) op = 7'h67;
         else              op = 7'($urandom);
         fw = ($urandom % 4 == 0) ? int'($urandom % 3) : 0;
         mw = ($urandom % 3 == 0) ? int'($urandom % 4) : 0;
         run_instr(op, fw, mw, (op == 7'h03) && ($urandom % 15 == 0) && (mw > 0));
      end

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
